// File: rtl/fetch_control.sv
// fetch_control: instruction-fetch controller resolving jumps/branches, load-use stalls and IF/ID staging
// Ports: clk/reset (async, active-low); ins/current_address from program memory; rs_data/rs_addr
// register-file read; jmp_loc/pc_mux_sel/stall/stall_pm back to PC and memory; id_* IF/ID stage; halted.
module fetch_control #(
  parameter int AW = 16,
  parameter int IW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] ins,
  input  logic [AW-1:0] current_address,
  input  logic [15:0]   rs_data,
  output logic [3:0]    rs_addr,
  output logic [AW-1:0] jmp_loc,
  output logic          pc_mux_sel,
  output logic          stall,
  output logic          stall_pm,
  output logic          id_valid,
  output logic [IW-1:0] id_ins,
  output logic [AW-1:0] id_pc,
  output logic          halted
);
  typedef enum logic [1:0] {RUN, REPLAY, FLUSH, HALT} state_t;
  state_t        r_state, w_next;
  logic          r_id_valid, r_ld_pend;
  logic [IW-1:0] r_id_ins;
  logic [AW-1:0] r_id_pc;
  logic [3:0]    r_ld_rd;
  logic [3:0]    w_op, w_rd, w_rs, w_rt;
  logic          w_uses_rs, w_uses_rt, w_hazard, w_taken, w_branch;
  logic          w_stall, w_sel, w_issue;
  assign w_op = ins[31:28];
  assign w_rd = ins[27:24];
  assign w_rs = ins[23:20];
  assign w_rt = ins[19:16];
  assign w_uses_rs = (w_op >= 4'h1 && w_op <= 4'h9) || w_op == 4'hB || w_op == 4'hC;
  assign w_uses_rt = (w_op >= 4'h1 && w_op <= 4'h7) || w_op == 4'h9;
  assign w_hazard = r_ld_pend && ((w_uses_rs && r_ld_rd == w_rs) || (w_uses_rt && r_ld_rd == w_rt));
  assign w_branch = w_op == 4'hB || w_op == 4'hC;
  assign w_taken = w_op == 4'hA || (w_op == 4'hB && rs_data == 16'd0) || (w_op == 4'hC && rs_data != 16'd0);
  always_comb begin
    w_next = r_state;
    w_stall = 1'b0;
    w_sel = 1'b0;
    w_issue = 1'b0;
    if (r_state == HALT) begin
      w_stall = 1'b1;
    end else if (r_state == FLUSH) begin
      w_next = RUN;
    end else if (w_op == 4'hF) begin
      w_stall = 1'b1;
      w_next = HALT;
    end else if (r_state == RUN && w_hazard) begin
      // the held instruction comes back under REPLAY, where this check is skipped
      w_stall = 1'b1;
      w_next = REPLAY;
    end else if (w_taken) begin
      w_sel = 1'b1;
      w_next = FLUSH;
    end else begin
      w_issue = !w_branch;
      w_next = RUN;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_id_valid <= 1'b0;
      r_id_ins <= '0;
      r_id_pc <= '0;
      r_ld_pend <= 1'b0;
      r_ld_rd <= 4'd0;
    end else begin
      r_state <= w_next;
      r_id_valid <= w_issue;
      if (w_issue) begin
        r_id_ins <= ins;
        r_id_pc <= current_address;
      end
      r_ld_pend <= w_issue && w_op == 4'h8;
      r_ld_rd <= (w_issue && w_op == 4'h8) ? w_rd : 4'd0;
    end
  end
  assign rs_addr = w_rs;
  assign jmp_loc = AW'(ins[15:0]);
  assign pc_mux_sel = reset && w_sel;
  assign stall = reset && w_stall;
  assign stall_pm = reset && w_stall;
  assign id_valid = r_id_valid;
  assign id_ins = r_id_ins;
  assign id_pc = r_id_pc;
  assign halted = r_state == HALT;
endmodule
